// File: rtl/spi_reg_responder.sv
// Register-access command responder behind an SPI slave byte interface.
// Decodes read/write frames from received bytes and returns data through the slave TX path.
module spi_reg_responder #(
    parameter int NUM_REGS = 8,
    parameter int NUM_RO   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_SS,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    output logic [7:0]            o_TX_Byte,
    output logic                  o_TX_DV,
    input  logic [NUM_RO*8-1:0]   i_ro_data,
    output logic [NUM_REGS*8-1:0] o_regs,
    output logic                  o_wr_strobe,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic                  o_err,
    output logic                  o_frame_done
);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              ss_q, ss_fall, ss_rise, rx_ok;
    logic [ADDR_W-1:0] addr_q, addr_d, cmd_addr, next_addr, wr_addr_d;
    logic              auto_q, auto_d, cmd_bad;
    logic [7:0]        tx_byte_d;
    logic              tx_dv_d, wr_en_d, err_d;
    logic [7:0]        regs_q [NUM_RO:NUM_REGS-1];

    assign ss_fall  = ss_q & ~i_SS;
    assign ss_rise  = ~ss_q & i_SS;
    // A byte arriving on the SS rising-edge cycle still belongs to the frame.
    assign rx_ok    = i_RX_DV & ~ss_q & (state_q != IDLE);
    assign cmd_addr = i_RX_Byte[ADDR_W-1:0];
    assign cmd_bad  = int'(i_RX_Byte[5:0]) >= NUM_REGS;
    assign next_addr = !auto_q ? addr_q :
                       (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;

    // Read-only slots expose the live sensor inputs; only RW slots have storage.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k < NUM_RO) begin : g_ro
            assign o_regs[k*8 +: 8] = i_ro_data[k*8 +: 8];
        end else begin : g_rw
            assign o_regs[k*8 +: 8] = regs_q[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every comb output gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        if (ss_rise)
            state_d = IDLE;
        else if (ss_fall)
            state_d = CMD;
        else if (rx_ok && state_q == CMD)
            state_d = cmd_bad ? DRAIN : (i_RX_Byte[7] ? READ : WRITE);
    end

    always_comb begin
        tx_byte_d = o_TX_Byte;
        tx_dv_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = o_wr_addr;
        err_d     = ss_fall ? 1'b0 : o_err;
        addr_d    = addr_q;
        auto_d    = auto_q;
        if (rx_ok) begin
            tx_dv_d = 1'b1;
            unique case (state_q)
                CMD: begin
                    auto_d = i_RX_Byte[6];
                    addr_d = cmd_addr;
                    if (cmd_bad) begin
                        err_d     = 1'b1;
                        tx_byte_d = 8'hFF;
                    end else if (i_RX_Byte[7]) begin
                        tx_byte_d = o_regs[{cmd_addr, 3'b000} +: 8];
                    end else begin
                        tx_byte_d = {o_err, 7'd0};
                    end
                end
                READ: begin
                    addr_d    = next_addr;
                    tx_byte_d = o_regs[{next_addr, 3'b000} +: 8];
                end
                WRITE: begin
                    tx_byte_d = o_regs[{addr_q, 3'b000} +: 8];
                    addr_d    = next_addr;
                    if (int'(addr_q) < NUM_RO) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                    end
                end
                default: tx_byte_d = 8'hFF;
            endcase
        end
    end

    // NOTE: the register file is reset with the rest so an aborted frame leaves no partial write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_q         <= 1'b1;
            addr_q       <= '0;
            auto_q       <= 1'b0;
            o_TX_Byte    <= 8'h00;
            o_TX_DV      <= 1'b0;
            o_wr_strobe  <= 1'b0;
            o_wr_addr    <= '0;
            o_err        <= 1'b0;
            o_frame_done <= 1'b0;
            for (int k = NUM_RO; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
        end else begin
            ss_q         <= i_SS;
            addr_q       <= addr_d;
            auto_q       <= auto_d;
            o_TX_Byte    <= tx_byte_d;
            o_TX_DV      <= tx_dv_d;
            o_wr_strobe  <= wr_en_d;
            o_wr_addr    <= wr_addr_d;
            o_err        <= err_d;
            o_frame_done <= ss_rise;
            if (wr_en_d) regs_q[addr_q] <= i_RX_Byte;
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: register frames, error cases and reset abort.
module tb_spi_reg_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_SS;
    logic        i_RX_DV;
    logic [7:0]  i_RX_Byte;
    logic [7:0]  o_TX_Byte;
    logic        o_TX_DV;
    logic [15:0] i_ro_data;
    logic [63:0] o_regs;
    logic        o_wr_strobe;
    logic [2:0]  o_wr_addr;
    logic        o_err;
    logic        o_frame_done;

    int vectors     = 0;
    int miscompares = 0;

    spi_reg_responder dut (
        .clk         (clk),
        .rst         (rst),
        .i_SS        (i_SS),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_TX_Byte   (o_TX_Byte),
        .o_TX_DV     (o_TX_DV),
        .i_ro_data   (i_ro_data),
        .o_regs      (o_regs),
        .o_wr_strobe (o_wr_strobe),
        .o_wr_addr   (o_wr_addr),
        .o_err       (o_err),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses RX_DV for one clock; returns on the following falling edge with outputs settled.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge clk);
        i_RX_DV   = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] exp_tx, input string tag);
        send(b);
        check({tag, "_dv"}, 64'(o_TX_DV), 64'd1);
        check({tag, "_tx"}, 64'(o_TX_Byte), 64'(exp_tx));
    endtask

    task automatic ss_low();
        @(negedge clk);
        i_SS = 1'b0;
    endtask

    task automatic ss_high(input string tag);
        @(negedge clk);
        i_SS = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, 64'(o_frame_done), 64'd1);
        @(negedge clk);
        check({tag, "_done_off"}, 64'(o_frame_done), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        i_SS      = 1'b1;
        i_RX_DV   = 1'b0;
        i_RX_Byte = 8'h00;
        i_ro_data = 16'hA53C;
        #12;
        check("rst_tx",    64'(o_TX_Byte), 64'h00);
        check("rst_dv",    64'(o_TX_DV), 64'd0);
        check("rst_strb",  64'(o_wr_strobe), 64'd0);
        check("rst_waddr", 64'(o_wr_addr), 64'd0);
        check("rst_err",   64'(o_err), 64'd0);
        check("rst_done",  64'(o_frame_done), 64'd0);
        check("rst_regs",  o_regs, 64'h0000_0000_0000_A53C);
        @(negedge clk);
        rst = 1'b1;

        // Single write to reg3.
        ss_low();
        xfer(8'h03, 8'h00, "w1_status");
        check("w1_nostrb", 64'(o_wr_strobe), 64'd0);
        xfer(8'h5A, 8'h00, "w1_echo");
        check("w1_strb",  64'(o_wr_strobe), 64'd1);
        check("w1_waddr", 64'(o_wr_addr), 64'd3);
        @(negedge clk);
        check("w1_strb_off", 64'(o_wr_strobe), 64'd0);
        check("w1_dv_off",   64'(o_TX_DV), 64'd0);
        ss_high("w1");
        check("w1_err",  64'(o_err), 64'd0);
        check("w1_reg3", 64'(o_regs[31:24]), 64'h5A);

        // Auto-increment write to reg6/reg7.
        ss_low();
        xfer(8'h46, 8'h00, "w2_status");
        xfer(8'h11, 8'h00, "w2_echo6");
        check("w2_waddr6", 64'(o_wr_addr), 64'd6);
        xfer(8'h22, 8'h00, "w2_echo7");
        check("w2_waddr7", 64'(o_wr_addr), 64'd7);
        ss_high("w2");

        // Burst read wrapping from reg7 into the read-only mirrors.
        ss_low();
        xfer(8'hC6, 8'h11, "r_reg6");
        xfer(8'h00, 8'h22, "r_reg7");
        xfer(8'h00, 8'h3C, "r_reg0");
        i_ro_data = 16'hA5C3;
        @(negedge clk);
        check("r_snapshot", 64'(o_TX_Byte), 64'h3C);
        check("r_dv_off",   64'(o_TX_DV), 64'd0);
        xfer(8'h00, 8'hA5, "r_reg1");
        ss_high("r");

        // Write to a read-only register.
        ss_low();
        xfer(8'h01, 8'h00, "ro_status");
        xfer(8'hFF, 8'hA5, "ro_echo");
        check("ro_nostrb", 64'(o_wr_strobe), 64'd0);
        check("ro_err",    64'(o_err), 64'd1);
        ss_high("ro");
        check("ro_err_sticky", 64'(o_err), 64'd1);
        check("ro_reg1",       64'(o_regs[15:8]), 64'hA5);

        // Bad address drains the frame; the falling edge clears the old error first.
        ss_low();
        @(negedge clk);
        check("bad_err_clr", 64'(o_err), 64'd0);
        xfer(8'h8A, 8'hFF, "bad_cmd");
        check("bad_err", 64'(o_err), 64'd1);
        xfer(8'h55, 8'hFF, "bad_d1");
        xfer(8'h66, 8'hFF, "bad_d2");
        check("bad_nostrb", 64'(o_wr_strobe), 64'd0);
        ss_high("bad");
        check("bad_regs", o_regs, 64'h2211_0000_5A00_A5C3);

        // Data byte on the same cycle as the SS rising edge.
        ss_low();
        xfer(8'h04, 8'h00, "edge_status");
        @(negedge clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'h77;
        i_SS      = 1'b1;
        @(negedge clk);
        i_RX_DV = 1'b0;
        check("edge_dv",    64'(o_TX_DV), 64'd1);
        check("edge_echo",  64'(o_TX_Byte), 64'h00);
        check("edge_strb",  64'(o_wr_strobe), 64'd1);
        check("edge_waddr", 64'(o_wr_addr), 64'd4);
        check("edge_done",  64'(o_frame_done), 64'd1);
        @(negedge clk);
        check("edge_reg4", 64'(o_regs[39:32]), 64'h77);

        // Byte with SS high is ignored.
        send(8'h99);
        check("sshi_dv",   64'(o_TX_DV), 64'd0);
        check("sshi_strb", 64'(o_wr_strobe), 64'd0);
        check("sshi_regs", o_regs, 64'h2211_0077_5A00_A5C3);

        // Asynchronous reset in the middle of a burst write.
        ss_low();
        xfer(8'h45, 8'h00, "ab_status");
        xfer(8'hAA, 8'h00, "ab_echo5");
        xfer(8'hBB, 8'h11, "ab_echo6");
        check("ab_strb", 64'(o_wr_strobe), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ab_regs",  o_regs, 64'h0000_0000_0000_A5C3);
        check("ab_tx",    64'(o_TX_Byte), 64'h00);
        check("ab_strb0", 64'(o_wr_strobe), 64'd0);
        check("ab_waddr", 64'(o_wr_addr), 64'd0);
        check("ab_err",   64'(o_err), 64'd0);
        i_SS = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        ss_low();
        xfer(8'hC5, 8'h00, "ab_rd5");
        xfer(8'h00, 8'h00, "ab_rd6");
        xfer(8'h00, 8'h00, "ab_rd7");
        xfer(8'h00, 8'hC3, "ab_rd0");
        check("ab_err_end", 64'(o_err), 64'd0);
        ss_high("ab");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
Slave-side command responder that sits behind one SPI slave byte interface. It takes received MOSI bytes (RX_DV/RX_Byte) and decodes them as register-access frames. It returns read data by driving the slave's TX_Byte/TX_DV, so the master sees the data on MISO in the following byte transfer. It gives each monitoring node a small register file: read-only sensor mirrors plus read/write control registers.

Parameters:
NUM_REGS, 8, total registers; addresses 0..NUM_REGS-1
NUM_RO, 2, registers 0..NUM_RO-1 are read-only mirrors of i_ro_data
ADDR_W, $clog2(NUM_REGS), internal address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
i_SS  in  1  slave select, active-low, synchronous to clk; frame = SS low period
i_RX_DV  in  1  one-cycle pulse, i_RX_Byte valid
i_RX_Byte  in  8  byte received on MOSI
o_TX_Byte  out  8  byte to shift out on MISO in the next transfer
o_TX_DV  out  1  one-cycle load strobe for o_TX_Byte
i_ro_data  in  NUM_RO*8  sensor values; byte k maps to register k
o_regs  out  NUM_REGS*8  flat register file; byte k = register k
o_wr_strobe  out  1  one-cycle pulse per committed write
o_wr_addr  out  ADDR_W  address of the committed write
o_err  out  1  sticky frame error flag
o_frame_done  out  1  one-cycle pulse on SS rising edge

Behaviour:
- Reset (rst=0, async): state IDLE, all RW registers 8'h00, o_TX_Byte=8'h00, o_TX_DV=0, o_wr_strobe=0, o_wr_addr=0, o_err=0, o_frame_done=0, SS history register=1.
- SS edge detection: registered SS_q, compared with i_SS. Falling edge starts a frame: enter CMD and clear o_err. Rising edge: o_frame_done=1 for one cycle, return to IDLE from any state.
- Command byte (first RX_DV in frame):
  - bit7 = 1 read / 0 write; bit6 = auto-increment; bits[5:0] = address.
  - Address >= NUM_REGS: set o_err, go to DRAIN (ignore remaining bytes, TX 8'hFF on each RX_DV).
- States: IDLE, CMD, WRITE, READ, DRAIN.
- READ:
  - On the command byte, load o_TX_Byte = reg[addr] and pulse o_TX_DV exactly 1 cycle after the command RX_DV.
  - Every subsequent RX_DV (dummy byte, value ignored): advance addr if auto-increment is set, then load and pulse the next byte with the same 1-cycle latency.
- WRITE:
  - On the command byte, load o_TX_Byte = {o_err,7'd0} (status) with a 1-cycle TX_DV pulse.
  - Each data RX_DV: echo the old reg[addr] on o_TX_Byte/o_TX_DV (1 cycle); write the byte into reg[addr]; pulse o_wr_strobe with o_wr_addr=addr; advance addr if auto-increment is set.
  - Write to a read-only address (addr < NUM_RO): no update, no strobe, set o_err; the echo still occurs.
- Auto-increment wraps from NUM_REGS-1 to 0. Without auto-increment, addr stays fixed (repeated reads/writes of the same register).
- Registers 0..NUM_RO-1 read i_ro_data sampled on the cycle the byte is loaded (snapshot; no further change once loaded).
- RX_DV in the same cycle as the SS rising edge: the byte is fully processed (write committed) and o_frame_done is also pulsed. The state still ends in IDLE.
- RX_DV while SS is high or in IDLE: ignored, no TX_DV.
- Reset mid-frame: immediate abort; registers are cleared to 0 and no partial write survives.
- o_TX_DV never pulses on two consecutive cycles.
- o_wr_strobe and o_TX_DV may coincide.

Test Plan:
- Reset then write frame: SS low, bytes 8'h03, 8'h5A, SS high -> reg3=8'h5A; o_wr_strobe 1 pulse with o_wr_addr=3; TX bytes 8'h00 (status), 8'h00 (old reg3); o_frame_done 1 pulse; o_err=0.
- Burst read with auto-increment: reg6=8'h11, reg7=8'h22, reg0 mirrors i_ro_data[7:0]=8'h3C. Command 8'hC6 plus 3 dummy bytes -> TX sequence 8'h11, 8'h22, 8'h3C (wrap). Each TX_DV arrives exactly 1 clk after its RX_DV.
- Read-only write: command 8'h01, data 8'hFF -> reg1 is unchanged; no wr_strobe; o_err=1 until the next SS falling edge, which clears it to 0.
- Bad address: command 8'h8A with NUM_REGS=8 -> o_err=1; every following RX_DV yields TX 8'hFF; no register changes.
- Boundary cases:
  - RX_DV of data byte 8'h77 in the same cycle as SS rising -> reg committed = 8'h77 and o_frame_done pulses.
  - RX_DV with SS high -> no TX_DV, no write.
- Async reset asserted mid-burst-write (after 2 of 4 bytes) -> outputs and registers return to reset values in the same cycle. The next frame decodes its first byte as a command.
